// File: rtl/tilelink_ul_pkg.sv
// Shared TL-UL definitions: A/D opcodes, responder FSM states.
package tilelink_ul_pkg;

  localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
  localparam logic [2:0] GET_A              = 3'd4;

  localparam logic [2:0] ACCESS_ACK_D       = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA_D  = 3'd1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tilelink_ul_rsp_fifo.sv
// Response FIFO: push visible on head one cycle later; push ignored when full, pop ignored when empty.
module tilelink_ul_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tilelink_ul_mem_responder.sv
// TL-UL responder over a word memory cleared after reset; response visible one cycle after acceptance.
// a_ready falls only while the response FIFO is full; TL_UL_RESP_STATS_EN adds req/err counters.
module tilelink_ul_mem_responder
  import tilelink_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_OPCODE_WIDTH = 3,
  parameter int TL_PARAM_WIDTH  = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int MEM_DEPTH       = 16,
  parameter int RSP_DEPTH       = 2,
  parameter int SINK_ID         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
`ifdef TL_UL_RESP_STATS_EN
  ,
  output logic [31:0]                req_count,
  output logic [31:0]                err_count
`endif
);

  localparam int OFF  = $clog2(TL_STRB_WIDTH);
  localparam int IDXW = $clog2(MEM_DEPTH);

  typedef struct packed {
    logic [TL_OPCODE_WIDTH-1:0] opcode;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [TL_DATA_WIDTH-1:0]   data;
    logic                       error;
  } rsp_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   init_idx;
  logic              init_we;
  logic              ready;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  rsp_t              rsp_in;
  rsp_t              rsp_head;
  logic [IDXW-1:0]   word_idx;
  logic              is_put;
  logic              is_get;
  logic              misaligned;
  logic              err;
  logic              unused_param;
  logic [TL_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_idx <= init_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_idx == IDXW'(MEM_DEPTH - 1)) state_nxt = RUN;
  end

  always_comb begin
    init_we = (state == INIT);
    ready   = (state == RUN) && !fifo_full;
  end

  assign a_ready = ready;
  assign accept  = a_valid && ready;

  assign word_idx = a_address[OFF +: IDXW];
  assign is_put   = (a_opcode == TL_OPCODE_WIDTH'(PUT_FULL_DATA_A)) ||
                    (a_opcode == TL_OPCODE_WIDTH'(PUT_PARTIAL_DATA_A));
  assign is_get   = (a_opcode == TL_OPCODE_WIDTH'(GET_A));

  always_comb begin
    misaligned = 1'b0;
    for (int i = 0; i < OFF; i++) begin
      if (TL_SIZE_WIDTH'(i) < a_size && a_address[i]) misaligned = 1'b1;
    end
  end

  // Any address bit above the memory index means the word does not exist.
  assign err = !(is_put || is_get) || (a_size > TL_SIZE_WIDTH'(OFF)) || misaligned ||
               (|a_address[TL_ADDR_WIDTH-1:OFF+IDXW]);

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= '0;
    end else if (accept && is_put && !err) begin
      for (int b = 0; b < TL_STRB_WIDTH; b++) begin
        if (a_mask[b]) mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_in.opcode = is_get ? TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D) : TL_OPCODE_WIDTH'(ACCESS_ACK_D);
    rsp_in.size   = a_size;
    rsp_in.source = a_source;
    rsp_in.data   = (is_get && !err) ? mem[word_idx] : '0;
    rsp_in.error  = err;
  end

  tilelink_ul_rsp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (rsp_in),
    .pop       (d_ready),
    .head      (rsp_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign d_valid  = !fifo_empty;
  assign d_opcode = d_valid ? rsp_head.opcode : '0;
  assign d_size   = d_valid ? rsp_head.size   : '0;
  assign d_source = d_valid ? rsp_head.source : '0;
  assign d_data   = d_valid ? rsp_head.data   : '0;
  assign d_error  = d_valid && rsp_head.error;
  assign d_param  = '0;
  assign d_sink   = TL_SINK_WIDTH'(SINK_ID);

  assign unused_param = ^a_param;

`ifdef TL_UL_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      req_count <= req_count + 32'd1;
      if (err) err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tilelink_ul_mem_responder.sv
// Bench for tilelink_ul_mem_responder: directed vector table, stall/drain and reset sequences, random traffic.
module tb_tilelink_ul_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [63:0] a_address = '0;
  logic [7:0]  a_size = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic [2:0]  a_source = '0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [7:0]  d_size;
  logic [2:0]  d_sink;
  logic [2:0]  d_source;
  logic [63:0] d_data;
  logic        d_error;
`ifdef TL_UL_RESP_STATS_EN
  logic [31:0] req_count;
  logic [31:0] err_count;
`endif

  tilelink_ul_mem_responder dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_sink(d_sink), .d_source(d_source), .d_data(d_data), .d_error(d_error)
`ifdef TL_UL_RESP_STATS_EN
    , .req_count(req_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [7:0]  size;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  src;
  } req_t;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  size;
    logic [2:0]  src;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    req_t        rq;
    logic [2:0]  eop;
    logic        eerr;
    logic [63:0] edata;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  rsp_t        expq[$];
  logic [63:0] mm [16];
  int          tally_req = 0;
  int          tally_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decide the response from the protocol rules and update a plain word array.
  task automatic model(input req_t r, output rsp_t e);
    logic err;
    int   idx;
    err = !(r.op == 3'd0 || r.op == 3'd1 || r.op == 3'd4) || (r.size > 8'd3) ||
          ((r.addr / 64'd8) >= 64'd16);
    if (!err && (r.addr % (64'd1 << r.size)) != 64'd0) err = 1'b1;
    idx    = int'((r.addr / 64'd8) % 64'd16);
    e.op   = (r.op == 3'd4) ? 3'd1 : 3'd0;
    e.size = r.size;
    e.src  = r.src;
    e.err  = err;
    e.data = '0;
    if (!err) begin
      if (r.op == 3'd4) e.data = mm[idx];
      else
        for (int b = 0; b < 8; b++)
          if (r.mask[b]) mm[idx][8*b +: 8] = r.data[8*b +: 8];
    end
    tally_req++;
    if (err) tally_err++;
  endtask

  task automatic issue(input req_t r, input bit use_exp, input rsp_t ex);
    int   budget;
    rsp_t m;
    a_opcode = r.op; a_address = r.addr; a_size = r.size; a_mask = r.mask;
    a_data = r.data; a_source = r.src; a_param = 3'($urandom_range(0, 7));
    a_valid = 1'b1;
    budget = 0;
    while (!a_ready && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!a_ready) begin
      chk("a_ready_wait", a_ready, 1);
      a_valid = 1'b0;
      return;
    end
    model(r, m);
    expq.push_back(use_exp ? ex : m);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    d_ready = 1'b1;
    budget = 0;
    while ((expq.size() != 0 || d_valid) && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain_outstanding", 64'(expq.size()), 0);
    chk("drain_d_valid", d_valid, 0);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 16; i++) begin
      chk("init_a_ready_low", a_ready, 0);
      @(posedge clk); #1;
    end
    chk("run_a_ready_high", a_ready, 1);
  endtask

  function automatic req_t mkr(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                               input logic [7:0] mask, input logic [63:0] data, input logic [2:0] src);
    req_t r;
    r.op = op; r.addr = addr; r.size = size; r.mask = mask; r.data = data; r.src = src;
    return r;
  endfunction

  function automatic rsp_t mke(input req_t r, input logic [2:0] op, input logic err, input logic [63:0] data);
    rsp_t e;
    e.op = op; e.size = r.size; e.src = r.src; e.err = err; e.data = data;
    return e;
  endfunction

  // D-channel checker: a beat is consumed at the next rising edge when d_valid & d_ready here.
  always @(negedge clk) begin
    rsp_t e;
    if (rst && d_valid && d_ready) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL d_unexpected: got beat src=%0d with nothing outstanding, expected none", d_source);
      end else begin
        e = expq.pop_front();
        if (d_opcode !== e.op || d_size !== e.size || d_source !== e.src || d_data !== e.data ||
            d_error !== e.err || d_param !== 3'd0 || d_sink !== 3'd0) begin
          n_bad++;
          $display("FAIL d_beat: got op=%0d size=%0d src=%0d data=%h err=%0b param=%0d sink=%0d expected op=%0d size=%0d src=%0d data=%h err=%0b param=0 sink=0",
                   d_opcode, d_size, d_source, d_data, d_error, d_param, d_sink,
                   e.op, e.size, e.src, e.data, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[18];
    rsp_t dummy;
    req_t r;
    bit   done;

    dummy = '{op: 3'd0, size: 8'd0, src: 3'd0, data: 64'd0, err: 1'b0};
    tv[0]  = '{mkr(3'd4, 64'h0,    8'd3, 8'hFF, 64'h0, 3'd0), 3'd1, 1'b0, 64'h0};
    tv[1]  = '{mkr(3'd0, 64'h8,    8'd3, 8'hFF, 64'h1122334455667788, 3'd5), 3'd0, 1'b0, 64'h0};
    tv[2]  = '{mkr(3'd4, 64'h8,    8'd3, 8'hFF, 64'h0, 3'd3), 3'd1, 1'b0, 64'h1122334455667788};
    tv[3]  = '{mkr(3'd1, 64'h8,    8'd0, 8'h01, 64'hAA, 3'd1), 3'd0, 1'b0, 64'h0};
    tv[4]  = '{mkr(3'd4, 64'h8,    8'd3, 8'hFF, 64'h0, 3'd6), 3'd1, 1'b0, 64'h11223344556677AA};
    tv[5]  = '{mkr(3'd4, 64'h1000, 8'd3, 8'hFF, 64'h0, 3'd2), 3'd1, 1'b1, 64'h0};
    tv[6]  = '{mkr(3'd4, 64'h4,    8'd3, 8'hFF, 64'h0, 3'd4), 3'd1, 1'b1, 64'h0};
    tv[7]  = '{mkr(3'd4, 64'h8,    8'd3, 8'hFF, 64'h0, 3'd0), 3'd1, 1'b0, 64'h11223344556677AA};
    tv[8]  = '{mkr(3'd2, 64'h10,   8'd3, 8'hFF, 64'hDEAD, 3'd3), 3'd0, 1'b1, 64'h0};
    tv[9]  = '{mkr(3'd4, 64'h10,   8'd3, 8'hFF, 64'h0, 3'd1), 3'd1, 1'b0, 64'h0};
    tv[10] = '{mkr(3'd0, 64'h78,   8'd3, 8'hFF, 64'hCAFEF00D12345678, 3'd7), 3'd0, 1'b0, 64'h0};
    tv[11] = '{mkr(3'd4, 64'h78,   8'd3, 8'hFF, 64'h0, 3'd2), 3'd1, 1'b0, 64'hCAFEF00D12345678};
    tv[12] = '{mkr(3'd4, 64'h80,   8'd3, 8'hFF, 64'h0, 3'd5), 3'd1, 1'b1, 64'h0};
    tv[13] = '{mkr(3'd4, 64'h0,    8'd4, 8'hFF, 64'h0, 3'd6), 3'd1, 1'b1, 64'h0};
    tv[14] = '{mkr(3'd4, 64'hA,    8'd1, 8'hFF, 64'h0, 3'd7), 3'd1, 1'b0, 64'h11223344556677AA};
    tv[15] = '{mkr(3'd4, 64'hB,    8'd1, 8'hFF, 64'h0, 3'd0), 3'd1, 1'b1, 64'h0};
    tv[16] = '{mkr(3'd0, 64'hC,    8'd3, 8'hFF, 64'h0, 3'd1), 3'd0, 1'b1, 64'h0};
    tv[17] = '{mkr(3'd4, 64'h8,    8'd3, 8'hFF, 64'h0, 3'd4), 3'd1, 1'b0, 64'h11223344556677AA};

    for (int i = 0; i < 16; i++) mm[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_opcode", d_opcode, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_d_error", d_error, 0);
    chk("rst_d_sink", d_sink, 0);
`ifdef TL_UL_RESP_STATS_EN
    chk("rst_req_count", req_count, 0);
    chk("rst_err_count", err_count, 0);
`endif
    rst = 1'b1;
    wait_init();

    // Directed vector table, back to back with the D side always ready.
    d_ready = 1'b1;
    for (int i = 0; i < 18; i++)
      issue(tv[i].rq, 1'b1, mke(tv[i].rq, tv[i].eop, tv[i].eerr, tv[i].edata));
    drain();
`ifdef TL_UL_RESP_STATS_EN
    chk("table_req_count", req_count, 18);
    chk("table_err_count", err_count, 7);
`endif

    // D stalled: two Gets fill the FIFO, the third waits until the first pop.
    d_ready = 1'b0;
    issue(mkr(3'd4, 64'h8, 8'd3, 8'hFF, 64'h0, 3'd1), 1'b0, dummy);
    issue(mkr(3'd4, 64'h78, 8'd3, 8'hFF, 64'h0, 3'd2), 1'b0, dummy);
    chk("full_a_ready", a_ready, 0);
    fork
      issue(mkr(3'd4, 64'h0, 8'd3, 8'hFF, 64'h0, 3'd3), 1'b0, dummy);
      begin
        for (int k = 0; k < 2; k++) begin
          @(posedge clk); #1;
          chk("stall_a_ready", a_ready, 0);
          chk("stall_d_valid", d_valid, 1);
          chk("stall_d_source", d_source, 1);
          chk("stall_d_data", d_data, 64'h11223344556677AA);
        end
        d_ready = 1'b1;
        #1;
        chk("no_comb_d_ready_path", a_ready, 0);
        @(posedge clk); #1;
        chk("a_ready_after_pop", a_ready, 1);
      end
    join
    drain();

    // Random traffic with random D backpressure.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          case ($urandom_range(0, 9))
            0, 1, 2: r.op = 3'd4;
            3, 4:    r.op = 3'd0;
            5, 6:    r.op = 3'd1;
            default: r.op = 3'($urandom_range(0, 7));
          endcase
          r.addr = 64'($urandom_range(0, 17)) * 64'd8;
          if ($urandom_range(0, 3) == 0) r.addr = r.addr + 64'($urandom_range(0, 7));
          if ($urandom_range(0, 19) == 0) r.addr = r.addr | (64'd1 << $urandom_range(7, 63));
          r.size = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
          r.mask = 8'($urandom_range(0, 255));
          r.data = {$urandom, $urandom};
          r.src  = 3'($urandom_range(0, 7));
          issue(r, 1'b0, dummy);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          d_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
`ifdef TL_UL_RESP_STATS_EN
    chk("rand_req_count", req_count, 64'(tally_req));
    chk("rand_err_count", err_count, 64'(tally_err));
`endif

    // Reset with responses in flight: they are dropped and memory is cleared again.
    d_ready = 1'b0;
    issue(mkr(3'd4, 64'h8, 8'd3, 8'hFF, 64'h0, 3'd1), 1'b0, dummy);
    issue(mkr(3'd4, 64'h10, 8'd3, 8'hFF, 64'h0, 3'd2), 1'b0, dummy);
    chk("pre_reset_d_valid", d_valid, 1);
    rst = 1'b0;
    #1;
    chk("midrst_d_valid", d_valid, 0);
    chk("midrst_a_ready", a_ready, 0);
`ifdef TL_UL_RESP_STATS_EN
    chk("midrst_req_count", req_count, 0);
    chk("midrst_err_count", err_count, 0);
`endif
    expq.delete();
    for (int i = 0; i < 16; i++) mm[i] = '0;
    tally_req = 0;
    tally_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    wait_init();
    d_ready = 1'b1;
    issue(tv[1].rq, 1'b1, mke(tv[1].rq, 3'd0, 1'b0, 64'h0));
    issue(tv[2].rq, 1'b1, mke(tv[2].rq, 3'd1, 1'b0, 64'h1122334455667788));
    issue(tv[5].rq, 1'b1, mke(tv[5].rq, 3'd1, 1'b1, 64'h0));
    issue(tv[6].rq, 1'b1, mke(tv[6].rq, 3'd1, 1'b1, 64'h0));
    drain();
`ifdef TL_UL_RESP_STATS_EN
    chk("post_req_count", req_count, 4);
    chk("post_err_count", err_count, 2);
`endif
    r = mkr(3'd4, 64'h78, 8'd3, 8'hFF, 64'h0, 3'd5);
    issue(r, 1'b1, mke(r, 3'd1, 1'b0, 64'h0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
